// File: rtl/booth_operand_prep_if.sv
// Operand/result bus for the Booth operand-prep front end.
// The master is the producer/consumer side. The slave is the prep block.
interface booth_operand_prep_if #(
    parameter int bits = 32
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic                signed_mode;
    logic [bits-1:0]     a;
    logic [bits-1:0]     b;
    logic                out_valid;
    logic                out_ready;
    logic [2*bits-1:0]   x;
    logic [2*bits-1:0]   _x;
    logic [2*bits-1:0]   zx;
    logic [2*bits-1:0]   _zx;
    logic [bits+2:0]     y;

    modport master (
        output flush, in_valid, signed_mode, a, b, out_ready,
        input  in_ready, out_valid, x, _x, zx, _zx, y
    );

    modport slave (
        input  flush, in_valid, signed_mode, a, b, out_ready,
        output in_ready, out_valid, x, _x, zx, _zx, y
    );
endinterface

// File: rtl/booth_operand_prep.sv
// Two-stage operand preparation for the radix-4 Booth multiplier.
// Stage 1 captures the operands and builds the extended X and the y word.
// Stage 2 registers the Booth multiples +X, -X, +2X and -2X.
// All outputs come straight from stage-2 registers.
module booth_operand_prep #(
    parameter int bits = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_operand_prep_if.slave  bus
);
    localparam int W = 2 * bits;

    logic            r_v1, r_v2;
    logic [W-1:0]    r_x1;
    logic [bits+2:0] r_y1;
    logic [W-1:0]    r_x, r_nx, r_zx, r_nzx;
    logic [bits+2:0] r_y;

    logic            w_in_hs, w_out_hs, w_s2_load;
    logic            w_ext_a, w_ext_b;
    logic [W-1:0]    w_x2;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign bus.in_ready = !r_v1 || !r_v2 || bus.out_ready;
    assign w_in_hs      = bus.in_valid && bus.in_ready;
    assign w_out_hs     = r_v2 && bus.out_ready;
    assign w_s2_load    = r_v1 && (!r_v2 || bus.out_ready);

    assign w_ext_a = bus.a[bits-1] & bus.signed_mode;
    assign w_ext_b = bus.b[bits-1] & bus.signed_mode;
    assign w_x2    = {r_x1[W-2:0], 1'b0};

    // Valid bits. flush empties both stages and takes priority over any handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (bus.flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_in_hs)
                r_v1 <= 1'b1;
            else if (w_s2_load)
                r_v1 <= 1'b0;
            if (w_s2_load)
                r_v2 <= 1'b1;
            else if (w_out_hs)
                r_v2 <= 1'b0;
        end
    end

    // Stage 1: build the extended multiplicand and the padded multiplier word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1 <= '0;
            r_y1 <= '0;
        end else if (w_in_hs && !bus.flush) begin
            r_x1 <= {{bits{w_ext_a}}, bus.a};
            r_y1 <= {w_ext_b, w_ext_b, bus.b, 1'b0};
        end
    end

    // Stage 2: register the Booth multiples. Negations wrap modulo 2^W.
    // These registers change only when stage 2 loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x   <= '0;
            r_nx  <= '0;
            r_zx  <= '0;
            r_nzx <= '0;
            r_y   <= '0;
        end else if (w_s2_load && !bus.flush) begin
            r_x   <= r_x1;
            r_nx  <= ~r_x1 + 1'b1;
            r_zx  <= w_x2;
            r_nzx <= ~w_x2 + 1'b1;
            r_y   <= r_y1;
        end
    end

    assign bus.out_valid = r_v2;
    assign bus.x         = r_x;
    assign bus._x        = r_nx;
    assign bus.zx        = r_zx;
    assign bus._zx       = r_nzx;
    assign bus.y         = r_y;
endmodule

// File: tb/tb_booth_operand_prep.sv
// Randomised and directed bench for booth_operand_prep (bits=32) with a queue scoreboard.
module tb_booth_operand_prep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_operand_prep_if #(.bits(32)) bus ();
    booth_operand_prep #(.bits(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] x, nx, zx, nzx;
        logic [34:0] y;
        int          cyc;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pops = 0;
    bit   lat_on = 1'b0;
    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the sign- or zero-extended values.
    function automatic exp_t model(input bit s, input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        logic [63:0] xv, bx;
        xv    = s ? 64'($signed(av)) : 64'(av);
        bx    = s ? 64'($signed(bv)) : 64'(bv);
        e.x   = xv;
        e.nx  = 64'd0 - xv;
        e.zx  = xv * 64'd2;
        e.nzx = 64'd0 - xv * 64'd2;
        e.y   = 35'(bx * 64'd2);
        e.cyc = 0;
        return e;
    endfunction

    // Scoreboard: handshakes are decided by the values seen between edges.
    always @(negedge clk) begin
        exp_t e;
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    pops++;
                    chk("sb_x", bus.x, e.x);
                    chk("sb_nx", bus._x, e.nx);
                    chk("sb_zx", bus.zx, e.zx);
                    chk("sb_nzx", bus._zx, e.nzx);
                    chk("sb_y", 64'(bus.y), 64'(e.y));
                    if (lat_on) chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.signed_mode, bus.a, bus.b);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic [31:0] av, input logic [31:0] bv);
        bus.in_valid    = 1'b1;
        bus.signed_mode = s;
        bus.a           = av;
        bus.b           = bv;
    endtask

    // Hold the operands until they are accepted, giving up after a cycle budget.
    task automatic send(input bit s, input logic [31:0] av, input logic [31:0] bv);
        bit ok;
        drive(s, av, bv);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input bit s, input logic [31:0] av, input logic [31:0] bv,
                            input logic [63:0] ex, input logic [63:0] enx,
                            input logic [63:0] ezx, input logic [63:0] enzx,
                            input logic [34:0] ey);
        send(s, av, bv);
        @(negedge clk);
        chk("dir_vld_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("dir_vld", 64'(bus.out_valid), 64'd1);
        chk("dir_x", bus.x, ex);
        chk("dir_nx", bus._x, enx);
        chk("dir_zx", bus.zx, ezx);
        chk("dir_nzx", bus._zx, enzx);
        chk("dir_y", 64'(bus.y), 64'(ey));
        step();
    endtask

    initial begin
        exp_t e0;
        int   p0;
        bus.flush = 0; bus.in_valid = 0; bus.signed_mode = 0;
        bus.a = '0; bus.b = '0; bus.out_ready = 1;
        #12;
        chk("rst_vld", 64'(bus.out_valid), 64'd0);
        chk("rst_x", bus.x, 64'd0);
        chk("rst_y", 64'(bus.y), 64'd0);
        rst = 1'b0;
        step();
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);

        // Directed vectors
        directed(1, 32'd3, 32'd5, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD, 64'h6,
                 64'hFFFF_FFFF_FFFF_FFFA, 35'h0_0000_000A);
        directed(1, 32'hFFFF_FFFF, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'h2, 35'h7_0000_0000);
        directed(0, 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_0000_0001, 64'h1_FFFF_FFFE, 64'hFFFF_FFFE_0000_0002,
                 35'h1_0000_0000);
        directed(1, 32'h8000_0000, 32'h0, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
                 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 35'h0);
        directed(1, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 35'h0);

        // Backpressure: two sets fill the pipe, then it must hold still.
        bus.out_ready = 1'b0;
        p0 = pops;
        e0 = model(0, 32'h1234_5678, 32'h9ABC_DEF0);
        send(0, 32'h1234_5678, 32'h9ABC_DEF0);
        send(1, 32'hDEAD_BEEF, 32'h0000_0007);
        drive(1, 32'h0000_00FF, 32'hFFFF_FFF0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdy", 64'(bus.in_ready), 64'd0);
            chk("bp_vld", 64'(bus.out_valid), 64'd1);
            chk("bp_x", bus.x, e0.x);
            chk("bp_nzx", bus._zx, e0.nzx);
            step();
        end
        bus.out_ready = 1'b1;
        send(1, 32'h0000_00FF, 32'hFFFF_FFF0);
        send(0, 32'h7FFF_FFFF, 32'h8000_0001);
        for (int i = 0; i < 4; i++) step();
        chk("bp_count", 64'(pops - p0), 64'd4);
        chk("bp_empty", 64'(q.size()), 64'd0);

        // Full-throughput random stream.
        lat_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'($urandom), $urandom, $urandom);
            @(negedge clk);
            chk("tp_rdy", 64'(bus.in_ready), 64'd1);
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        lat_on = 1'b0;
        chk("tp_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), $urandom, $urandom);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 64'(bus.out_valid), 64'd0);
        chk("arst_x", bus.x, 64'd0);
        chk("arst_nx", bus._x, 64'd0);
        chk("arst_zx", bus.zx, 64'd0);
        chk("arst_nzx", bus._zx, 64'd0);
        chk("arst_y", 64'(bus.y), 64'd0);
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("arst_rdy", 64'(bus.in_ready), 64'd1);

        // Flush with two sets in flight, and a third presented during the flush.
        bus.out_ready = 1'b0;
        send(1, 32'h1111_1111, 32'h2222_2222);
        send(0, 32'h3333_3333, 32'h4444_4444);
        drive(1, 32'h5555_5555, 32'h6666_6666);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_vld", 64'(bus.out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("fl_vld2", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        step();
        p0 = pops;
        directed(1, 32'hFFFF_FFF6, 32'h0000_0010, 64'hFFFF_FFFF_FFFF_FFF6, 64'hA,
                 64'hFFFF_FFFF_FFFF_FFEC, 64'h14, 35'h20);
        step();
        chk("fl_count", 64'(pops - p0), 64'd1);
        chk("fl_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_operand_prep.md
# booth_operand_prep

Two-stage pipelined operand-preparation front end for the radix-4 Booth multiplier. It accepts a pair of `bits`-wide operands under a valid/ready handshake and extends the multiplicand to `2*bits` (signed or unsigned). It then precomputes the four Booth multiples +X, −X, +2X and −2X, and forms the zero-padded, extended multiplier word. The registered results drive the Booth partial-product/Wallace-tree compressor inputs directly (x, _x, zx, _zx, y).

## Interface
- `bits`, default 32: operand width; the Booth-multiple outputs are `2*bits` wide and the multiplier output is `bits+3` wide.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `flush` input 1: synchronous clear; drops all in-flight operands.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: block can accept an operand pair this cycle.
- `signed_mode` input 1: 1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- `a` input `bits`: multiplicand.
- `b` input `bits`: multiplier.
- `out_valid` output 1: prepared operand set present.
- `out_ready` input 1: consumer accepts the set this cycle.
- `x` output `2*bits`: extended multiplicand (+X).
- `_x` output `2*bits`: −X, two's complement, modulo 2^(2*bits).
- `zx` output `2*bits`: +2X, which is X<<1 modulo 2^(2*bits).
- `_zx` output `2*bits`: −2X, modulo 2^(2*bits).
- `y` output `bits+3`: {ext, ext, b, 1'b0}.
  - ext = b[bits-1] when `signed_mode`=1, else 0.

## Operation
Stage 1 (S1) is the capture register:
- On an in-handshake (`in_valid && in_ready`), store `a`, `b` and `signed_mode` and set `v1`.
- Compute X = {`bits`{a[bits-1] & signed_mode}, a}.
- Compute the `y` word.

Stage 2 (S2) is the multiple register:
- Register X, −X = ~X+1, 2X = {X[2*bits-2:0],1'b0}, −2X = ~2X+1, and `y` from S1. Set `v2`.
- The outputs are driven directly from the S2 registers. `out_valid` = `v2`.

Pipeline advance rules:
- S2 loads when `v1 && (!v2 || out_ready)`.
- S1 loads on an in-handshake.
- `v1` clears when S1 transfers to S2 without a new load.
- `v2` clears on an out-handshake with no S2 load that cycle.
- `in_ready` = `!v1 || !v2 || out_ready` (combinational from `out_ready` only).

Boundary conditions:
- Full (`v1`=`v2`=1, `out_ready`=0): `in_ready`=0. All S1/S2 contents and outputs are held bit-stable.
- Simultaneous out-handshake, S1→S2 transfer and in-handshake: all three happen in one cycle, with no bubble and no loss.
- `a` = most-negative value in signed mode: −X and −2X wrap modulo 2^(2*bits). No overflow flag is produced.
- Zero operands: all multiples are 0 and `y` is 0.
- `flush`: next edge `v1`=`v2`=0. An input presented in the same cycle is discarded. Data registers may keep stale values.
- `flush` has priority over handshakes. `rst` has priority over everything.

Reset values (async, immediate):
- `v1`=`v2`=0, so `out_valid`=0.
- `x`, `_x`, `zx`, `_zx`, `y` = 0.
- `in_ready` = 1 once `rst` is deasserted.

## Timing
- Latency: input accepted at edge N → `out_valid`=1 after edge N+1, with data valid in that cycle.
- Throughput: one operand set per cycle when `out_ready` is held high.
- Data outputs change only on edges where S2 loads.
- `in_ready` has no path from `in_valid`. Outputs have no combinational path from inputs.

## Test plan
- Signed, a=3, b=5 → two cycles later `out_valid`=1, with:
  - `x`=64'h3, `_x`=64'hFFFF_FFFF_FFFF_FFFD
  - `zx`=64'h6, `_zx`=64'hFFFF_FFFF_FFFF_FFFA
  - `y`=35'h0_0000_000A
- Signed, a=32'hFFFF_FFFF, b=32'h8000_0000 → `x`=64'hFFFF_FFFF_FFFF_FFFF, `_x`=64'h1, `zx`=64'hFFFF_FFFF_FFFF_FFFE, `_zx`=64'h2, `y`=35'h7_0000_0000.
- Same operands unsigned → `x`=64'h0000_0000_FFFF_FFFF, `_x`=64'hFFFF_FFFF_0000_0001, `zx`=64'h1_FFFF_FFFE, `_zx`=64'hFFFF_FFFE_0000_0002, `y`=35'h1_0000_0000.
- Backpressure:
  - Stimulus: stream 4 sets with `out_ready`=0 for 5 cycles.
  - After 2 accepts, `in_ready`=0 and outputs stay stable.
  - Then raise `out_ready` → sets exit in order with no loss or duplication, one per cycle.
- Full-throughput stream of 16 random signed/unsigned sets with `out_ready`=1 → `in_ready` stays 1 and each output matches the reference model exactly 2 cycles after input.
- Reset and flush:
  - Assert `rst` mid-stream → `out_valid` drops to 0 immediately and all outputs are 0.
  - Assert `flush` with 2 sets in flight → `out_valid`=0 next cycle, and a subsequent set emerges with correct values.
